data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the internal array; must be a power of two.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  high only in IDLE; a request is accepted in any cycle with req_valid and req_ready both high.
REQ-006 SHALL have port req_addr  input  32  byte address, the ALU result.
REQ-007 SHALL have port req_wdata  input  32  store data; sub-word stores use the low byte or halfword.
REQ-008 SHALL have port req_wr_en  input  1  1 = store, 0 = load; driven by wr_en_dmem.
REQ-009 SHALL have port req_rw_mode  input  4  access size, matched against the common library constants BYTE, HALFWORD and WORD; any other value is treated as WORD.
REQ-010 SHALL have port req_unsigned  input  1  funct3[2] of the instruction; 1 = zero-extend loads.
REQ-011 SHALL have port resp_valid  output  1  single-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; registered and held until the next load response.
REQ-013 SHALL have port resp_err  output  1  misaligned access; valid only with resp_valid.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE and RESP.
REQ-015 SHALL latch addr, wdata, wr_en, rw_mode and unsigned on acceptance; input changes afterwards have no effect on the operation in flight.
REQ-016 SHALL index the array by word index = req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so out-of-range addresses wrap.
REQ-017 SHALL sequence each operation as follows, with the accept cycle counted as cycle 0:
- load: IDLE→READ→RESP, resp_valid in cycle 2;
- WORD store: IDLE→WRITE→RESP, resp_valid in cycle 2;
- BYTE/HALFWORD store: IDLE→READ→WRITE→RESP, read-modify-write, resp_valid in cycle 3.
REQ-018 SHALL select the load lane by addr[1:0] for BYTE and addr[1] for HALFWORD, then sign-extend, or zero-extend when req_unsigned=1.
REQ-019 SHALL ignore req_unsigned for WORD loads.
REQ-020 SHALL, on a sub-word store, modify only the addressed byte or halfword lane; all other lanes keep their prior value.
REQ-021 SHALL go from RESP to IDLE unconditionally; requests are never pipelined, and req_ready returns high in the cycle after resp_valid.
REQ-022 SHALL accept no request while req_ready=0; req_valid in those cycles is ignored and not queued.
REQ-023 SHALL NOT change resp_rdata on a store response.
REQ-024 SHALL NOT write the array in any state other than WRITE.

Reset
REQ-025 SHALL, while rst_n=0, force: state IDLE; req_ready=1 after deassertion; resp_valid=0, resp_rdata=0, resp_err=0.
REQ-026 SHALL, on reset during READ, abort the operation and write nothing to the array.
REQ-027 SHALL, on reset during WRITE before the clock edge, leave the target word unmodified.
REQ-028 SHALL NOT clear array contents on reset.

Configuration
REQ-029 SHALL, with DMEM_MISALIGN_TRAP_EN defined, treat a HALFWORD access with addr[0]=1, or a WORD access with addr[1:0]≠0, as misaligned: IDLE→RESP, resp_valid in cycle 1 with resp_err=1, no array access, resp_rdata unchanged.
REQ-030 SHALL, without DMEM_MISALIGN_TRAP_EN, force misaligned addresses to alignment by ignoring the low offending bits, proceed normally and hold resp_err at 0.

Verification
REQ-031 SHALL pass: WORD store 0xDEADBEEF to 0x10, then WORD load from 0x10 → resp_rdata=0xDEADBEEF, resp_valid in cycle 2 of each operation.
REQ-032 SHALL pass: BYTE store 0x000000A5 to 0x13 over word 0x11223344 → word reads 0xA5223344; BYTE load from 0x13 → 0xFFFFFFA5; with req_unsigned=1 → 0x000000A5.
REQ-033 SHALL pass: HALFWORD load from 0x12 of 0x80017FFF → 0xFFFF8001; from 0x10 → 0x00007FFF.
REQ-034 SHALL pass: WORD load from 0x11 with the macro → resp_err=1 in cycle 1 and memory untouched; without the macro → returns the word at 0x10 with resp_err=0.
REQ-035 SHALL pass: rst_n low in the READ cycle of a BYTE store to 0x20 → word at 0x20 unchanged; after release, state IDLE, req_ready=1, resp_valid=0.
REQ-036 SHALL pass: req_valid held high continuously for two loads → second accepted only in the cycle after the first resp_valid; with DEPTH_WORDS=1024, address 0x1010 aliases to 0x0010.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data memory controller for the load/store unit.
// Handles one request at a time, supports BYTE/HALFWORD/WORD accesses with
// sign or zero extension on loads and read-modify-write for sub-word stores.
// Optional build macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// HALFWORD/WORD accesses complete immediately with resp_err=1 and no array
// access; when undefined, the offending low address bits are ignored.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request; latches it on req_valid
// S_READ  | array word read (load data, or old word for sub-word store)
// S_WRITE | array written (whole word or merged sub-word)
// S_RESP  | one-cycle completion pulse, then back to S_IDLE
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_wr_en,
  input  logic [3:0]  req_rw_mode,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Access-size encodings shared with the core's decode library.
  localparam logic [3:0] BYTE     = 4'b0001;
  localparam logic [3:0] HALFWORD = 4'b0011;
  localparam logic [3:0] WORD     = 4'b1111;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_wr_en;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [31:0]   r_rdword;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [1:0]    w_req_size;
  logic          w_misalign;
  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_mem_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_data;
  logic [31:0]   w_store_word;
  logic          w_unused_addr;

  // Upper address bits only select beyond the array, so addresses wrap.
  assign w_unused_addr = &{1'b0, req_addr[31:AW+2]};

  // Unknown size codes fall back to a full-word access.
  always_comb begin
    w_req_size = SZ_WORD;
    case (req_rw_mode)
      BYTE:     w_req_size = SZ_BYTE;
      HALFWORD: w_req_size = SZ_HALF;
      default:  w_req_size = SZ_WORD;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = ((w_req_size == SZ_HALF) && req_addr[0]) ||
                      ((w_req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_idx      = r_addr[AW+1:2];
  assign w_mem_word = r_mem[w_idx];

  // Lane select and extension of the word being read for a load.
  always_comb begin
    w_byte      = w_mem_word[7:0];
    w_half      = w_mem_word[15:0];
    w_load_data = w_mem_word;
    case (r_addr[1:0])
      2'd0:    w_byte = w_mem_word[7:0];
      2'd1:    w_byte = w_mem_word[15:8];
      2'd2:    w_byte = w_mem_word[23:16];
      default: w_byte = w_mem_word[31:24];
    endcase
    if (r_addr[1]) w_half = w_mem_word[31:16];
    case (r_size)
      SZ_BYTE: w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load_data = w_mem_word;
    endcase
  end

  // Merge store data into the previously read word for sub-word stores.
  always_comb begin
    w_store_word = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_store_word = r_rdword;
        case (r_addr[1:0])
          2'd0:    w_store_word[7:0]   = r_wdata[7:0];
          2'd1:    w_store_word[15:8]  = r_wdata[7:0];
          2'd2:    w_store_word[23:16] = r_wdata[7:0];
          default: w_store_word[31:24] = r_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        w_store_word = r_rdword;
        if (r_addr[1]) w_store_word[31:16] = r_wdata[15:0];
        else           w_store_word[15:0]  = r_wdata[15:0];
      end
      default: w_store_word = r_wdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misalign)                                 w_next_state = S_RESP;
          else if (req_wr_en && (w_req_size == SZ_WORD)) w_next_state = S_WRITE;
          else                                            w_next_state = S_READ;
        end
      end
      S_READ:  w_next_state = r_wr_en ? S_WRITE : S_RESP;
      S_WRITE: w_next_state = S_RESP;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request latch, read capture and registered load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wr_en    <= 1'b0;
      r_size     <= SZ_WORD;
      r_unsigned <= 1'b0;
      r_rdword   <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= req_addr[AW+1:0];
        r_wdata    <= req_wdata;
        r_wr_en    <= req_wr_en;
        r_size     <= w_req_size;
        r_unsigned <= req_unsigned;
        r_err      <= w_misalign;
      end
      if (r_state == S_READ) begin
        if (r_wr_en) r_rdword <= w_mem_word;
        else         r_rdata  <= w_load_data;
      end
    end
  end

  // Array write; contents survive reset and only S_WRITE touches them.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == S_WRITE)) r_mem[w_idx] <= w_store_word;
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl; expected values are hand-computed.
module tb_data_mem_ctrl;

  localparam logic [3:0] M_BYTE = 4'b0001;
  localparam logic [3:0] M_HALF = 4'b0011;
  localparam logic [3:0] M_WORD = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_wr_en;
  logic [3:0]  req_rw_mode;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] held;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wr_en    (req_wr_en),
    .req_rw_mode  (req_rw_mode),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request; inputs are scrambled after acceptance to prove they were latched.
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic wr, input logic [3:0] m, input logic u,
                    input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
    int          lat;
    logic [31:0] rd;
    logic        e;
    lat = -1;
    rd  = 32'h0;
    e   = 1'b0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_addr     = a;
    req_wdata    = d;
    req_wr_en    = wr;
    req_rw_mode  = m;
    req_unsigned = u;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_addr     = ~a;
    req_wdata    = ~d;
    req_wr_en    = ~wr;
    req_rw_mode  = ~m;
    req_unsigned = ~u;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        e   = resp_err;
        break;
      end
    end
    check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, " rdata"}, rd, exp_rd);
    check_val({tag, " err"}, 32'(e), 32'(exp_err));
    @(negedge clk);
    check_val({tag, " ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] m, input int exp_lat);
    op(tag, a, d, 1'b1, m, 1'b0, exp_lat, held, 1'b0);
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [3:0] m,
                    input logic u, input logic [31:0] exp);
    op(tag, a, 32'h0, 1'b0, m, u, 2, exp, 1'b0);
    held = exp;
  endtask

  // Store aborted by reset in cycle 1 (READ for sub-word, WRITE for word).
  task automatic abort_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] m);
    @(negedge clk);
    req_valid   = 1'b1;
    req_addr    = a;
    req_wdata   = d;
    req_wr_en   = 1'b1;
    req_rw_mode = m;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val({tag, " rst ready"}, 32'(req_ready), 32'd1);
    check_val({tag, " rst valid"}, 32'(resp_valid), 32'd0);
    check_val({tag, " rst rdata"}, resp_rdata, 32'h0);
    check_val({tag, " rst err"}, 32'(resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val({tag, " post ready"}, 32'(req_ready), 32'd1);
    check_val({tag, " post valid"}, 32'(resp_valid), 32'd0);
    held = 32'h0;
  endtask

  // Two loads with req_valid held high throughout.
  task automatic back_to_back();
    int          n_acc;
    int          n_resp;
    int          acc2;
    int          r1;
    int          r2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        acc_now;
    n_acc  = 0;
    n_resp = 0;
    acc2   = -1;
    r1     = -1;
    r2     = -1;
    d1     = 32'h0;
    d2     = 32'h0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_addr     = 32'h40;
    req_wr_en    = 1'b0;
    req_rw_mode  = M_WORD;
    req_unsigned = 1'b0;
    for (int c = 0; c < 20 && n_resp < 2; c++) begin
      if (c > 0) @(negedge clk);
      acc_now = req_valid && req_ready;
      if (resp_valid) begin
        if (n_resp == 0) begin r1 = c; d1 = resp_rdata; end
        else             begin r2 = c; d2 = resp_rdata; end
        n_resp++;
      end
      if (acc_now && n_acc == 1) acc2 = c;
      @(posedge clk);
      #1;
      if (acc_now) begin
        n_acc++;
        if (n_acc == 1) req_addr = 32'h44;
        else            req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check_val("b2b first resp cycle", 32'(r1), 32'd2);
    check_val("b2b second accept cycle", 32'(acc2), 32'd3);
    check_val("b2b second resp cycle", 32'(r2), 32'd5);
    check_val("b2b first data", d1, 32'hA1A2A3A4);
    check_val("b2b second data", d2, 32'hB1B2B3B4);
    held = 32'hB1B2B3B4;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_wr_en    = 1'b0;
    req_rw_mode  = M_WORD;
    req_unsigned = 1'b0;
    held         = 32'h0;
    repeat (3) @(negedge clk);
    check_val("reset valid", 32'(resp_valid), 32'd0);
    check_val("reset rdata", resp_rdata, 32'h0);
    check_val("reset err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("reset ready", 32'(req_ready), 32'd1);

    st("st_w10", 32'h10, 32'hDEADBEEF, M_WORD, 2);
    ld("ld_w10", 32'h10, M_WORD, 1'b0, 32'hDEADBEEF);
    ld("ld_w10_uns", 32'h10, M_WORD, 1'b1, 32'hDEADBEEF);

    st("st_w10_b", 32'h10, 32'h11223344, M_WORD, 2);
    st("st_b13", 32'h13, 32'h123456A5, M_BYTE, 3);
    ld("ld_w10_after_b", 32'h10, M_WORD, 1'b0, 32'hA5223344);
    ld("ld_b13_s", 32'h13, M_BYTE, 1'b0, 32'hFFFFFFA5);
    ld("ld_b13_u", 32'h13, M_BYTE, 1'b1, 32'h000000A5);
    ld("ld_b11_s", 32'h11, M_BYTE, 1'b0, 32'h00000033);
    ld("ld_b12_s", 32'h12, M_BYTE, 1'b0, 32'h00000022);

    st("st_w10_h", 32'h10, 32'h80017FFF, M_WORD, 2);
    ld("ld_h12_s", 32'h12, M_HALF, 1'b0, 32'hFFFF8001);
    ld("ld_h10_s", 32'h10, M_HALF, 1'b0, 32'h00007FFF);
    ld("ld_h12_u", 32'h12, M_HALF, 1'b1, 32'h00008001);
    st("st_h12", 32'h12, 32'hCAFEBEEF, M_HALF, 3);
    ld("ld_w10_after_h", 32'h10, M_WORD, 1'b0, 32'hBEEF7FFF);
    st("st_b10", 32'h10, 32'h00000080, M_BYTE, 3);
    ld("ld_b10_s", 32'h10, M_BYTE, 1'b0, 32'hFFFFFF80);
    ld("ld_mode0_word", 32'h10, 4'b0000, 1'b0, 32'hBEEF7F80);

`ifdef DMEM_MISALIGN_TRAP_EN
    op("ld_w11_trap", 32'h11, 32'h0, 1'b0, M_WORD, 1'b0, 1, held, 1'b1);
    op("st_w11_trap", 32'h11, 32'h0BADF00D, 1'b1, M_WORD, 1'b0, 1, held, 1'b1);
    op("ld_h13_trap", 32'h13, 32'h0, 1'b0, M_HALF, 1'b0, 1, held, 1'b1);
    ld("ld_w10_untouched", 32'h10, M_WORD, 1'b0, 32'hBEEF7F80);
`else
    ld("ld_w11_align", 32'h11, M_WORD, 1'b0, 32'hBEEF7F80);
    ld("ld_h13_align", 32'h13, M_HALF, 1'b0, 32'hFFFFBEEF);
    st("st_w13_align", 32'h13, 32'h0BADF00D, M_WORD, 2);
    ld("ld_w10_aligned_st", 32'h10, M_WORD, 1'b0, 32'h0BADF00D);
`endif

    st("st_alias", 32'h1010, 32'h55AA55AA, M_WORD, 2);
    ld("ld_alias", 32'h0010, M_WORD, 1'b0, 32'h55AA55AA);

    st("st_w40", 32'h40, 32'hA1A2A3A4, M_WORD, 2);
    st("st_w44", 32'h44, 32'hB1B2B3B4, M_WORD, 2);
    back_to_back();

    st("st_w20", 32'h20, 32'hCAFEF00D, M_WORD, 2);
    abort_store("abort_b20", 32'h20, 32'h00000077, M_BYTE);
    ld("ld_w20_kept", 32'h20, M_WORD, 1'b0, 32'hCAFEF00D);
    st("st_w24", 32'h24, 32'h13579BDF, M_WORD, 2);
    abort_store("abort_w24", 32'h24, 32'h00000000, M_WORD);
    ld("ld_w24_kept", 32'h24, M_WORD, 1'b0, 32'h13579BDF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
